// File: rtl/song_sequencer_if.sv
// Control and status bundle between the user controls, the song sequencer
// and the beeper. The master side issues transport commands; the slave side
// (the sequencer) drives the tone outputs and playback status.
interface song_sequencer_if;
   logic       start;
   logic       stop;
   logic       loop_en;
   logic [4:0] tone;
   logic       tone_en;
   logic       playing;
   logic [5:0] note_idx;
   logic       song_done;

   modport master (
      output start, stop, loop_en,
      input  tone, tone_en, playing, note_idx, song_done
   );

   modport slave (
      input  start, stop, loop_en,
      output tone, tone_en, playing, note_idx, song_done
   );
endinterface

// File: rtl/song_sequencer.sv
// Song sequencer: walks a fixed note table, holding each note for
// (dur+1) tempo units followed by a short silent gap, and drives the
// beeper tone code / enable from registers.
module song_sequencer #(
   parameter int TICK_CYCLES = 1500000,
   parameter int GAP_CYCLES  = 120000,
   parameter int SONG_LEN    = 32
) (
   input  logic           clk_in,
   input  logic           rst_n_in,
   song_sequencer_if.slave bus
);

   typedef enum logic [1:0] {IDLE, FETCH, NOTE, GAP} state_t;

   localparam logic [23:0] TICK     = 24'(TICK_CYCLES);
   localparam logic [23:0] GAP_LOAD = (GAP_CYCLES > 0) ? 24'(GAP_CYCLES - 1) : 24'd0;
   localparam logic [6:0]  LEN      = 7'(SONG_LEN);
   localparam logic [4:0]  END_CODE = 5'd31;

   state_t      state_reg;
   logic [23:0] timer_reg;
   logic [4:0]  tone_reg;
   logic        tone_en_reg;
   logic [5:0]  note_idx_reg;
   logic        song_done_reg;

   logic [7:0]  entry;
   logic [4:0]  entry_code;
   logic [2:0]  entry_dur;
   logic        end_of_song;
   logic        audible;
   logic [23:0] note_len;

   // Fixed melody: {code[4:0], dur[2:0]}; everything past the rest is the end marker.
   function automatic logic [7:0] song_rom(input logic [5:0] idx);
      case (idx)
         6'd0, 6'd3, 6'd4, 6'd7: song_rom = {5'd8,  3'd1};
         6'd1, 6'd5:             song_rom = {5'd9,  3'd1};
         6'd2, 6'd6:             song_rom = {5'd10, 3'd1};
         6'd8:                   song_rom = {5'd0,  3'd1};
         default:                song_rom = {END_CODE, 3'd0};
      endcase
   endfunction

   // Decode the table entry addressed by the current note index.
   always_comb begin
      entry       = song_rom(note_idx_reg);
      entry_code  = entry[7:3];
      entry_dur   = entry[2:0];
      end_of_song = (entry_code == END_CODE) || ({1'b0, note_idx_reg} >= LEN);
      audible     = (entry_code >= 5'd1) && (entry_code <= 5'd21);
      note_len    = (({21'd0, entry_dur} + 24'd1) * TICK) - 24'd1;
   end

   // Playback FSM with registered beeper outputs; stop overrides every state.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state_reg     <= IDLE;
         timer_reg     <= 24'd0;
         tone_reg      <= 5'd0;
         tone_en_reg   <= 1'b0;
         note_idx_reg  <= 6'd0;
         song_done_reg <= 1'b0;
      end else if (bus.stop) begin
         state_reg     <= IDLE;
         timer_reg     <= 24'd0;
         tone_reg      <= 5'd0;
         tone_en_reg   <= 1'b0;
         note_idx_reg  <= 6'd0;
         song_done_reg <= 1'b0;
      end else begin
         song_done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               tone_en_reg <= 1'b0;
               if (bus.start) begin
                  note_idx_reg <= 6'd0;
                  state_reg    <= FETCH;
               end
            end
            FETCH: begin
               tone_en_reg <= 1'b0;
               if (end_of_song) begin
                  if (bus.loop_en) begin
                     note_idx_reg <= 6'd0;
                  end else begin
                     state_reg     <= IDLE;
                     tone_reg      <= 5'd0;
                     song_done_reg <= 1'b1;
                  end
               end else begin
                  state_reg   <= NOTE;
                  tone_reg    <= entry_code;
                  tone_en_reg <= audible;
                  timer_reg   <= note_len;
               end
            end
            NOTE: begin
               if (timer_reg == 24'd0) begin
                  tone_en_reg <= 1'b0;
                  if (GAP_CYCLES == 0) begin
                     note_idx_reg <= note_idx_reg + 6'd1;
                     state_reg    <= FETCH;
                  end else begin
                     timer_reg <= GAP_LOAD;
                     state_reg <= GAP;
                  end
               end else begin
                  timer_reg <= timer_reg - 24'd1;
               end
            end
            GAP: begin
               tone_en_reg <= 1'b0;
               if (timer_reg == 24'd0) begin
                  note_idx_reg <= note_idx_reg + 6'd1;
                  state_reg    <= FETCH;
               end else begin
                  timer_reg <= timer_reg - 24'd1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.tone      = tone_reg;
   assign bus.tone_en   = tone_en_reg;
   assign bus.playing   = (state_reg != IDLE);
   assign bus.note_idx  = note_idx_reg;
   assign bus.song_done = song_done_reg;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: reset, note timing, full song, looping,
// stop/start priority, mid-note reset and the gapless variant.
module tb_song_sequencer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   song_sequencer_if bus ();
   song_sequencer_if bus0 ();

   song_sequencer #(.TICK_CYCLES(10), .GAP_CYCLES(2), .SONG_LEN(32)) dut (
      .clk_in(clk), .rst_n_in(rst_n), .bus(bus)
   );

   song_sequencer #(.TICK_CYCLES(10), .GAP_CYCLES(0), .SONG_LEN(32)) dut0 (
      .clk_in(clk), .rst_n_in(rst_n), .bus(bus0)
   );

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end else begin
         $display("check %s: got=%0d expected=%0d ok", tag, got, exp);
      end
   endtask

   // Advance n clock edges; samples land 1 time unit after the edge.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.start = 1'b0;  bus.stop = 1'b0;
      bus0.start = 1'b0; bus0.stop = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
   endtask

   // Start is raised after edge E and sampled at E+1 (the entry into FETCH).
   task automatic pulse_start();
      bus.start = 1'b1;
      tick(1);
      bus.start = 1'b0;
   endtask

   // Length of the current run of tone_en at level lvl, bounded.
   task automatic run_len(input logic lvl, output int n);
      n = 0;
      while (bus.tone_en == lvl && n < 200) begin
         n++;
         tick(1);
      end
   endtask

   int n, bad, rises, done_cnt, done_t, idx8_cnt, idx8_on, end_t, reloop_t, reloop_tone;
   int seq[$];
   logic prev_en;
   int exp_seq[8] = '{8, 9, 10, 8, 8, 9, 10, 8};

   initial begin
      bus.start = 1'b0;  bus.stop = 1'b0;  bus.loop_en = 1'b0;
      bus0.start = 1'b0; bus0.stop = 1'b0; bus0.loop_en = 1'b0;

      // Reset and idle
      do_reset();
      check_eq("rst_tone", int'(bus.tone), 0);
      check_eq("rst_tone_en", int'(bus.tone_en), 0);
      check_eq("rst_playing", int'(bus.playing), 0);
      check_eq("rst_note_idx", int'(bus.note_idx), 0);
      check_eq("rst_song_done", int'(bus.song_done), 0);
      bad = 0;
      for (int c = 0; c < 100; c++) begin
         tick(1);
         if (bus.tone != 0 || bus.tone_en || bus.playing || bus.note_idx != 0 || bus.song_done)
            bad++;
      end
      check_eq("idle_quiet_cycles", bad, 0);

      // First notes: timing of note, gap and fetch
      pulse_start();
      check_eq("fetch_playing", int'(bus.playing), 1);
      check_eq("fetch_tone_en", int'(bus.tone_en), 0);
      tick(1);
      check_eq("n0_tone", int'(bus.tone), 8);
      check_eq("n0_tone_en", int'(bus.tone_en), 1);
      check_eq("n0_idx", int'(bus.note_idx), 0);
      run_len(1'b1, n);
      check_eq("n0_high_len", n, 20);
      run_len(1'b0, n);
      check_eq("n0_low_len", n, 3);
      check_eq("n1_tone", int'(bus.tone), 9);
      check_eq("n1_idx", int'(bus.note_idx), 1);
      run_len(1'b1, n);
      check_eq("n1_high_len", n, 20);
      run_len(1'b0, n);
      check_eq("n1_low_len", n, 3);
      check_eq("n2_tone", int'(bus.tone), 10);
      check_eq("n2_idx", int'(bus.note_idx), 2);

      // Full song without looping
      do_reset();
      bus.loop_en = 1'b0;
      pulse_start();
      seq.delete();
      prev_en = 1'b0; done_cnt = 0; done_t = -1; idx8_cnt = 0; idx8_on = 0;
      for (int c = 1; c <= 260; c++) begin
         tick(1);
         if (bus.tone_en && !prev_en) seq.push_back(int'(bus.tone));
         prev_en = bus.tone_en;
         if (bus.song_done) begin
            done_cnt++;
            done_t = c;
         end
         if (bus.note_idx == 6'd8 && bus.playing) begin
            idx8_cnt++;
            if (bus.tone_en) idx8_on++;
         end
      end
      check_eq("song_note_count", seq.size(), 8);
      for (int i = 0; i < 8; i++)
         check_eq($sformatf("song_tone_%0d", i), (i < seq.size()) ? seq[i] : -1, exp_seq[i]);
      check_eq("song_done_count", done_cnt, 1);
      check_eq("song_done_time", done_t, 208);
      check_eq("rest_cycles", idx8_cnt, 23);
      check_eq("rest_audible_cycles", idx8_on, 0);
      check_eq("song_end_playing", int'(bus.playing), 0);

      // Looping playback over three passes
      do_reset();
      bus.loop_en = 1'b1;
      pulse_start();
      prev_en = 1'b0; rises = 0; done_cnt = 0; end_t = -1; reloop_t = -1; reloop_tone = -1;
      for (int c = 1; c <= 634; c++) begin
         tick(1);
         if (bus.tone_en && !prev_en) begin
            rises++;
            if (end_t >= 0 && reloop_t < 0) begin
               reloop_t = c;
               reloop_tone = int'(bus.tone);
            end
         end
         prev_en = bus.tone_en;
         if (bus.song_done) done_cnt++;
         if (bus.note_idx == 6'd9 && end_t < 0) end_t = c;
      end
      check_eq("loop_end_fetch_time", end_t, 207);
      check_eq("loop_restart_delay", reloop_t - end_t, 2);
      check_eq("loop_restart_tone", reloop_tone, 8);
      check_eq("loop_note_count", rises, 25);
      check_eq("loop_song_done", done_cnt, 0);
      bus.loop_en = 1'b0;

      // Stop during the third note, with a simultaneous start
      do_reset();
      pulse_start();
      n = 0;
      while (!(bus.note_idx == 6'd2 && bus.tone_en) && n < 200) begin
         tick(1);
         n++;
      end
      check_eq("stop_reached_note2", int'(n < 200), 1);
      tick(5);
      bus.stop = 1'b1;
      bus.start = 1'b1;
      tick(1);
      bus.stop = 1'b0;
      bus.start = 1'b0;
      check_eq("stop_tone_en", int'(bus.tone_en), 0);
      check_eq("stop_tone", int'(bus.tone), 0);
      check_eq("stop_idx", int'(bus.note_idx), 0);
      check_eq("stop_playing", int'(bus.playing), 0);
      tick(2);
      check_eq("stop_start_ignored", int'(bus.playing), 0);
      pulse_start();
      tick(1);
      check_eq("replay_tone", int'(bus.tone), 8);
      check_eq("replay_tone_en", int'(bus.tone_en), 1);

      // Reset asserted for one cycle in the middle of a note
      n = 0;
      while (!(bus.note_idx == 6'd1 && bus.tone_en) && n < 200) begin
         tick(1);
         n++;
      end
      check_eq("rst_mid_reached_note1", int'(n < 200), 1);
      tick(3);
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      check_eq("rst_mid_tone_en", int'(bus.tone_en), 0);
      check_eq("rst_mid_tone", int'(bus.tone), 0);
      check_eq("rst_mid_idx", int'(bus.note_idx), 0);
      check_eq("rst_mid_playing", int'(bus.playing), 0);

      // Gapless variant: one silent fetch cycle between notes
      bus0.start = 1'b1;
      tick(1);
      bus0.start = 1'b0;
      tick(1);
      check_eq("g0_n0_tone", int'(bus0.tone), 8);
      check_eq("g0_n0_tone_en", int'(bus0.tone_en), 1);
      n = 0;
      while (bus0.tone_en && n < 200) begin
         n++;
         tick(1);
      end
      check_eq("g0_high_len", n, 20);
      n = 0;
      while (!bus0.tone_en && n < 200) begin
         n++;
         tick(1);
      end
      check_eq("g0_low_len", n, 1);
      check_eq("g0_n1_tone", int'(bus0.tone), 9);
      check_eq("g0_n1_idx", int'(bus0.note_idx), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Plays a fixed melody by driving the tone code and tone enable of the downstream beeper (tone_en / tone[4:0], 5-bit codes 1..21 = L1..H7).
- Steps through an internal note table, holding each note for a programmable number of tempo units.
- Inserts a short silent gap between notes so repeated pitches articulate.
- Sits between the user controls (keys/debouncers) and the beeper; one 12 MHz clock domain.

Parameters:
- TICK_CYCLES, 1500000, clock cycles per duration unit (125 ms at 12 MHz); testbenches override it to a small value.
- GAP_CYCLES, 120000, silent cycles after every note (10 ms); 0 means no gap state.
- SONG_LEN, 32, note table depth; addresses 0..SONG_LEN-1.
- Constraint: 8*TICK_CYCLES < 2^24 and GAP_CYCLES < 2^24.

Ports:
- clk_in  input  1  system clock, 12 MHz
- rst_n_in  input  1  reset, synchronous, active-low
- start  input  1  one-cycle pulse, begin playback from entry 0
- stop  input  1  one-cycle pulse, abort playback
- loop_en  input  1  1 = restart at entry 0 on end of song
- tone  output  5  tone code to the beeper, registered
- tone_en  output  1  beeper enable, registered
- playing  output  1  high in any state except IDLE
- note_idx  output  6  table address of the current note
- song_done  output  1  one-cycle pulse on non-looping song end

Behaviour:
- Table entry is 8 bits: {code[4:0], dur[2:0]}. Note length = (dur+1)*TICK_CYCLES cycles.
- Code 0 is a rest: NOTE timing applies but tone_en stays 0. Code 31 is the end marker. Codes 22..30 are treated as rests.
- Table contents, entries 0..7: codes 8,9,10,8,8,9,10,8, each with dur=1. Entry 8: rest, dur=1. Entry 9: end marker. Remaining entries: end marker.
- Reset (rst_n_in low at a clock edge): state IDLE, tone=0, tone_en=0, playing=0, note_idx=0, song_done=0, timer=0. Reset mid-note silences the output on that same edge.
- Timer: one 24-bit down-counter shared by NOTE and GAP.
- FSM states: IDLE, FETCH, NOTE, GAP.
- IDLE: outputs silent. On start=1, set note_idx=0 and go to FETCH.
- FETCH (1 cycle, tone_en=0): read entry[note_idx].
  - End marker, or note_idx reached SONG_LEN: if loop_en, set note_idx=0 and stay in FETCH; else go to IDLE and pulse song_done for 1 cycle.
  - Otherwise: go to NOTE, load tone=code, set tone_en=(code in 1..21), load timer=(dur+1)*TICK_CYCLES-1.
- NOTE: decrement timer each cycle. At timer==0, go to GAP with timer=GAP_CYCLES-1 and tone_en=0. If GAP_CYCLES==0, go straight to FETCH with note_idx+1.
- GAP: tone holds its value, tone_en=0. At timer==0, set note_idx+1 and go to FETCH.
- Period per note = (dur+1)*TICK_CYCLES + GAP_CYCLES + 1 cycles. tone_en goes high on the edge that enters NOTE, i.e. 2 edges after start is sampled.
- stop=1 in any state: go to IDLE on the next edge with tone_en=0, tone=0, note_idx=0; no song_done pulse.
- start while playing: ignored. start and stop in the same cycle: stop wins.
- loop_en is sampled only in FETCH at the end marker.

Test Plan:
- Reset then idle, TICK_CYCLES=10, GAP_CYCLES=2: all outputs 0, playing=0, no change for 100 cycles.
- start pulse at edge E: tone=8 and tone_en=1 from edge E+2 for exactly 20 cycles; tone_en=0 for 3 cycles (2 gap + 1 fetch); then tone=9 for 20 cycles. note_idx steps 0,1,2.
- Full song, loop_en=0: tone sequence 8,9,10,8,8,9,10,8. Entry 8 (rest) holds tone_en=0 for 23 cycles. song_done pulses once, exactly 1 cycle, at 9*23+1 cycles after entering the first FETCH. playing then falls to 0.
- loop_en=1: after entry 8, tone=8 reappears 2 cycles after the end-marker fetch; song_done never asserts over 3 loops.
- stop during the third note (note_idx=2): next edge tone_en=0, tone=0, note_idx=0, playing=0. A start in the same cycle as stop is ignored. A later start replays from tone=8.
- rst_n_in low for 1 cycle mid-NOTE: outputs take reset values on that edge. With GAP_CYCLES=0, notes are back-to-back with a single tone_en=0 fetch cycle between them.
